// File: rtl/bip_debug_controller.sv
// rtl/bip_debug_controller.sv - UART command sequencer that loads, runs, steps and dumps the accumulator CPU
//
// Purpose: decodes host command bytes ('L' load, 'R' run, 'S' step, 'D' dump),
// writes program memory, gates the CPU clock enable and returns PC/ACC over UART.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_rx_data, i_rx_valid received UART byte and its one-cycle strobe
//   o_tx_data, o_tx_start byte to transmit and its one-cycle start strobe
//   i_tx_done             transmitter finished the current byte
//   o_pm_wr_en/addr/data  program-memory write port
//   o_cpu_en, o_cpu_reset CPU clock enable and reset
//   i_halt, i_pc, i_acc   CPU status: HLT decoded, program counter, accumulator
//   o_busy                controller is not in IDLE
module bip_debug_controller #(
  parameter int NB_ADDRESS     = 11,
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_DATA        = 16,
  parameter int NB_BYTE        = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic [NB_BYTE-1:0]        o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_pm_wr_en,
  output logic [NB_ADDRESS-1:0]     o_pm_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_pm_wr_data,
  output logic                      o_cpu_en,
  output logic                      o_cpu_reset,
  input  logic                      i_halt,
  input  logic [NB_ADDRESS-1:0]     i_pc,
  input  logic [NB_DATA-1:0]        i_acc,
  output logic                      o_busy
);

  localparam int NB_WORD = 2 * NB_BYTE;
  localparam int NB_SNAP = 4 * NB_BYTE;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = NB_BYTE'(8'h44);
  localparam logic [NB_BYTE-1:0] CMD_ABORT = NB_BYTE'(8'h48);

  typedef enum logic [2:0] {
    IDLE,
    LD_CNT,
    LD_HI,
    LD_LO,
    RUN,
    STEP,
    DUMP_SEND,
    DUMP_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_cpu_reset;
  logic [NB_ADDRESS-1:0] r_addr;
  logic [NB_BYTE-1:0]    r_words_left;
  logic [NB_BYTE-1:0]    r_hi;
  logic [NB_SNAP-1:0]    r_snap;
  logic [1:0]            r_sent;

  logic                  w_pulse_reset;
  logic                  w_snap_load;
  logic                  w_cnt_load;
  logic                  w_hi_load;
  logic                  w_word_done;
  logic                  w_shift;
  logic [NB_SNAP-1:0]    w_snap_value;

  // PC is zero-extended to a full 16-bit field so the dump is always 4 bytes.
  assign w_snap_value = {NB_WORD'(i_pc), NB_WORD'(i_acc)};
  assign o_cpu_reset  = r_cpu_reset;
  assign o_busy       = (r_state != IDLE);

  always_comb begin
    w_next_state  = r_state;
    w_pulse_reset = 1'b0;
    w_snap_load   = 1'b0;
    w_cnt_load    = 1'b0;
    w_hi_load     = 1'b0;
    w_word_done   = 1'b0;
    w_shift       = 1'b0;
    o_tx_data     = '0;
    o_tx_start    = 1'b0;
    o_pm_wr_en    = 1'b0;
    o_pm_wr_addr  = '0;
    o_pm_wr_data  = '0;
    o_cpu_en      = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: w_next_state = LD_CNT;
            CMD_RUN:  w_next_state = RUN;
            CMD_STEP: w_next_state = STEP;
            CMD_DUMP: begin
              w_snap_load  = 1'b1;
              w_next_state = DUMP_SEND;
            end
            default:  w_next_state = IDLE;
          endcase
        end
      end

      LD_CNT: begin
        if (i_rx_valid) begin
          w_cnt_load = 1'b1;
          if (i_rx_data == '0) begin
            w_pulse_reset = 1'b1;
            w_next_state  = IDLE;
          end else begin
            w_next_state = LD_HI;
          end
        end
      end

      LD_HI: begin
        if (i_rx_valid) begin
          w_hi_load    = 1'b1;
          w_next_state = LD_LO;
        end
      end

      LD_LO: begin
        if (i_rx_valid) begin
          w_word_done  = 1'b1;
          o_pm_wr_en   = 1'b1;
          o_pm_wr_addr = r_addr;
          o_pm_wr_data = NB_INSTRUCTION'({r_hi, i_rx_data});
          if (r_words_left == NB_BYTE'(1)) begin
            w_pulse_reset = 1'b1;
            w_next_state  = IDLE;
          end else begin
            w_next_state = LD_HI;
          end
        end
      end

      RUN: begin
        // HLT is never executed, and the abort byte freezes the CPU in the same cycle.
        o_cpu_en = !i_halt;
        if (i_halt) begin
          w_next_state = IDLE;
        end else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
          o_cpu_en     = 1'b0;
          w_next_state = IDLE;
        end
      end

      STEP: begin
        o_cpu_en     = !i_halt;
        w_next_state = IDLE;
      end

      DUMP_SEND: begin
        o_tx_start   = 1'b1;
        o_tx_data    = r_snap[NB_SNAP-1 -: NB_BYTE];
        w_next_state = DUMP_WAIT;
      end

      DUMP_WAIT: begin
        if (i_tx_done) begin
          w_shift = 1'b1;
          if (r_sent == 2'd3) begin
            w_next_state = IDLE;
          end else begin
            w_next_state = DUMP_SEND;
          end
        end
      end

      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cpu_reset  <= 1'b1;
      r_addr       <= '0;
      r_words_left <= '0;
      r_hi         <= '0;
      r_snap       <= '0;
      r_sent       <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cpu_reset <= w_pulse_reset;

      if (w_snap_load) begin
        r_snap <= w_snap_value;
        r_sent <= '0;
      end else if (w_shift) begin
        r_snap <= {r_snap[NB_SNAP-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
        r_sent <= r_sent + 2'd1;
      end

      if (w_cnt_load) begin
        r_words_left <= i_rx_data;
        r_addr       <= '0;
      end else if (w_word_done) begin
        r_words_left <= r_words_left - NB_BYTE'(1);
        r_addr       <= r_addr + NB_ADDRESS'(1);
      end

      if (w_hi_load) begin
        r_hi <= i_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_bip_debug_controller.sv
// tb/tb_bip_debug_controller.sv - randomized self-checking bench for bip_debug_controller
module tb_bip_debug_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        tx_done;
  logic        o_pm_wr_en;
  logic [10:0] o_pm_wr_addr;
  logic [15:0] o_pm_wr_data;
  logic        o_cpu_en;
  logic        o_cpu_reset;
  logic        halt_sig;
  logic [10:0] pc_sig;
  logic [15:0] acc_sig;
  logic        o_busy;

  always #5 clk = ~clk;

  bip_debug_controller #(
    .NB_ADDRESS(11), .NB_INSTRUCTION(16), .NB_DATA(16), .NB_BYTE(8)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(tx_done),
    .o_pm_wr_en(o_pm_wr_en), .o_pm_wr_addr(o_pm_wr_addr), .o_pm_wr_data(o_pm_wr_data),
    .o_cpu_en(o_cpu_en), .o_cpu_reset(o_cpu_reset),
    .i_halt(halt_sig), .i_pc(pc_sig), .i_acc(acc_sig),
    .o_busy(o_busy)
  );

  // Environment: program memory and a toy CPU (acc += operand) driven by the DUT.
  logic [15:0] env_mem [0:2047];
  logic        mem_init;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc;
  logic        ovr;
  logic [10:0] ovr_pc;
  logic [15:0] ovr_acc;

  assign pc_sig   = ovr ? ovr_pc : cpu_pc;
  assign acc_sig  = ovr ? ovr_acc : cpu_acc;
  assign halt_sig = (env_mem[pc_sig][15:11] == 5'd0);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) env_mem[i] <= 16'h0801;
    end else if (o_pm_wr_en) begin
      env_mem[o_pm_wr_addr] <= o_pm_wr_data;
    end
    if (o_cpu_reset) begin
      cpu_pc  <= '0;
      cpu_acc <= '0;
    end else if (o_cpu_en) begin
      cpu_pc  <= cpu_pc + 11'd1;
      cpu_acc <= cpu_acc + {5'd0, env_mem[cpu_pc][10:0]};
    end
  end

  // Monitor: records every observable event, sampled on the falling edge.
  logic [26:0] obs_wr [$];
  logic [7:0]  obs_tx [$];
  int          n_rst_cyc = 0;
  int          n_en_cyc  = 0;

  always @(negedge clk) begin
    if (o_pm_wr_en) obs_wr.push_back({o_pm_wr_addr, o_pm_wr_data});
    if (o_tx_start) obs_tx.push_back(o_tx_data);
    if (o_cpu_reset) n_rst_cyc++;
    if (o_cpu_en) n_en_cyc++;
  end

  // UART transmitter stand-in with random per-byte latency.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Reference model state
  logic [15:0] exp_mem [0:2047];
  logic [10:0] m_pc;
  logic [15:0] m_acc;
  logic [15:0] prog [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (o_busy === 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic model_exec();
    m_acc = m_acc + {5'd0, exp_mem[m_pc][10:0]};
    m_pc  = m_pc + 11'd1;
  endtask

  task automatic do_load(input int n);
    int base;
    int rb;
    base = obs_wr.size();
    rb   = n_rst_cyc;
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
      exp_mem[i] = prog[i];
    end
    wait_idle("load");
    repeat (2) @(negedge clk);
    check("load_nwr", obs_wr.size() - base, n);
    for (int i = 0; i < n && base + i < obs_wr.size(); i++)
      check("load_wr", {5'd0, obs_wr[base + i]}, {5'd0, i[10:0], prog[i]});
    check("load_rstpulse", n_rst_cyc - rb, 1);
    check("load_pc0", {21'd0, cpu_pc}, 32'd0);
    m_pc  = '0;
    m_acc = '0;
  endtask

  task automatic do_step();
    int be;
    int exp_en;
    be     = n_en_cyc;
    exp_en = 0;
    send_byte(8'h53);
    wait_idle("step");
    if (exp_mem[m_pc][15:11] != 5'd0) begin
      model_exec();
      exp_en = 1;
    end
    check("step_en", n_en_cyc - be, exp_en);
    check("step_pc", {21'd0, cpu_pc}, {21'd0, m_pc});
  endtask

  task automatic do_run();
    int be;
    int cnt;
    be  = n_en_cyc;
    cnt = 0;
    send_byte(8'h52);
    wait_idle("run");
    while (exp_mem[m_pc][15:11] != 5'd0 && cnt < 2048) begin
      model_exec();
      cnt++;
    end
    check("run_en", n_en_cyc - be, cnt);
    check("run_pc", {21'd0, cpu_pc}, {21'd0, m_pc});
  endtask

  task automatic do_dump(input logic [10:0] epc, input logic [15:0] eacc);
    int          tb0;
    int          wb;
    int          be;
    logic [31:0] snap;
    tb0  = obs_tx.size();
    wb   = obs_wr.size();
    be   = n_en_cyc;
    snap = {5'd0, epc, eacc};
    send_byte(8'h44);
    send_byte(8'h4C);
    send_byte(8'h52);
    wait_idle("dump");
    repeat (2) @(negedge clk);
    check("dump_nbytes", obs_tx.size() - tb0, 4);
    for (int i = 0; i < 4 && tb0 + i < obs_tx.size(); i++)
      check("dump_byte", {24'd0, obs_tx[tb0 + i]}, {24'd0, snap[31 - 8*i -: 8]});
    check("dump_nowr", obs_wr.size() - wb, 0);
    check("dump_noen", n_en_cyc - be, 0);
  endtask

  initial begin
    int          wb;
    int          tb0;
    int          be;
    int          n;
    int          h;
    logic [7:0]  junk;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ovr      = 1'b0;
    ovr_pc   = '0;
    ovr_acc  = '0;
    mem_init = 1'b1;
    for (int i = 0; i < 2048; i++) exp_mem[i] = 16'h0801;
    m_pc  = '0;
    m_acc = '0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_cpu_en", {31'd0, o_cpu_en}, 32'd0);
    check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_wr_en", {31'd0, o_pm_wr_en}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_cpu_reset_hold", {31'd0, o_cpu_reset}, 32'd1);
    @(negedge clk);
    check("rel_cpu_reset_fall", {31'd0, o_cpu_reset}, 32'd0);

    // Two-word load
    prog = '{16'h0805, 16'h1803};
    do_load(2);

    // Zero-length load, then address restarts at 0
    prog = '{};
    do_load(0);
    prog = '{16'hABCD};
    do_load(1);

    // Run to HLT at address 3
    prog = '{16'h0801, 16'h0802, 16'h0803, 16'h0000};
    do_load(4);
    do_run();
    check("hlt_pc3", {21'd0, cpu_pc}, 32'd3);
    do_dump(m_pc, m_acc);

    // Single steps, then dumps (forced status and real status)
    prog = '{16'h0801, 16'h0810, 16'h0000};
    do_load(3);
    do_step();
    do_step();
    ovr     = 1'b1;
    ovr_pc  = 11'h002;
    ovr_acc = 16'h1234;
    do_dump(11'h002, 16'h1234);
    ovr_pc  = 11'h7FF;
    ovr_acc = 16'hBEEF;
    do_dump(11'h7FF, 16'hBEEF);
    ovr = 1'b0;
    do_dump(m_pc, m_acc);

    // Abort a free run after 10 cycles
    prog = '{};
    for (int i = 0; i < 8; i++) prog.push_back({5'($urandom_range(1, 31)), 11'($urandom)});
    do_load(8);
    be = n_en_cyc;
    send_byte(8'h52);
    repeat (10) @(posedge clk);
    #1;
    rx_data  = 8'h48;
    rx_valid = 1'b1;
    @(negedge clk);
    check("abort_en_low", {31'd0, o_cpu_en}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", {31'd0, o_busy}, 32'd0);
    check("abort_en_cnt", n_en_cyc - be, 10);
    check("abort_pc", {21'd0, cpu_pc}, 32'd10);
    for (int i = 0; i < 10; i++) model_exec();
    do_dump(m_pc, m_acc);

    // Randomized sessions
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do junk = 8'($urandom);
        while (junk == 8'h4C || junk == 8'h52 || junk == 8'h53 || junk == 8'h44);
        wb  = obs_wr.size();
        tb0 = obs_tx.size();
        be  = n_en_cyc;
        send_byte(junk);
        wait_idle("junk");
        check("junk_nowr", obs_wr.size() - wb, 0);
        check("junk_notx", obs_tx.size() - tb0, 0);
        check("junk_noen", n_en_cyc - be, 0);
      end
      n = $urandom_range(1, 10);
      h = $urandom_range(0, n - 1);
      prog = '{};
      for (int i = 0; i < n; i++) begin
        if (i == h) prog.push_back({5'd0, 11'($urandom)});
        else        prog.push_back({5'($urandom_range(1, 31)), 11'($urandom)});
      end
      do_load(n);
      repeat ($urandom_range(0, 3)) do_step();
      do_dump(m_pc, m_acc);
      do_run();
      check("rand_halt_pc", {21'd0, cpu_pc}, h);
      do_dump(m_pc, m_acc);
    end

    // Reset in the middle of a load
    wb = obs_wr.size();
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'h11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_nowr", obs_wr.size() - wb, 0);
    check("midrst_idle", {31'd0, o_busy}, 32'd0);
    prog = '{16'h2222};
    do_load(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
